// File: rtl/fft_frame_scheduler_if.sv
// fft_frame_scheduler_if
//   Bundles every non-clock/reset signal of fft_frame_scheduler.
//   master : the scheduler side (drives channel reads, FFT input, results, status)
//   slave  : the environment side (channel FIFOs, FFT core, result sinks)
//   Signals:
//     ch_req, ch_di_re, ch_di_im      channel request level and FWFT sample data
//     ch_rd                           one-hot read strobe to the granted channel
//     fft_di_en/re/im                 sample stream into the FFT core
//     fft_do_en/re/im                 sample stream out of the FFT core
//     out_en/re/im/ch/sof/eof         tagged result stream
//     busy, err                       status (err is sticky)
interface fft_frame_scheduler_if #(
   parameter int WIDTH = 16,
   parameter int NCH   = 2,
   parameter int CHW   = $clog2(NCH)
) ();
   logic [NCH-1:0]          ch_req;
   logic [NCH*WIDTH-1:0]    ch_di_re;
   logic [NCH*WIDTH-1:0]    ch_di_im;
   logic [NCH-1:0]          ch_rd;
   logic                    fft_di_en;
   logic signed [WIDTH-1:0] fft_di_re;
   logic signed [WIDTH-1:0] fft_di_im;
   logic                    fft_do_en;
   logic signed [WIDTH-1:0] fft_do_re;
   logic signed [WIDTH-1:0] fft_do_im;
   logic                    out_en;
   logic signed [WIDTH-1:0] out_re;
   logic signed [WIDTH-1:0] out_im;
   logic [CHW-1:0]          out_ch;
   logic                    out_sof;
   logic                    out_eof;
   logic                    busy;
   logic [1:0]              err;

   modport master (
      input  ch_req, ch_di_re, ch_di_im, fft_do_en, fft_do_re, fft_do_im,
      output ch_rd, fft_di_en, fft_di_re, fft_di_im,
      output out_en, out_re, out_im, out_ch, out_sof, out_eof, busy, err
   );

   modport slave (
      output ch_req, ch_di_re, ch_di_im, fft_do_en, fft_do_re, fft_do_im,
      input  ch_rd, fft_di_en, fft_di_re, fft_di_im,
      input  out_en, out_re, out_im, out_ch, out_sof, out_eof, busy, err
   );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler
//   Shares one SDF FFT pipeline between NCH frame-buffered requesters. Whole
//   N-sample frames are granted round-robin and streamed as one contiguous
//   di_en burst; each frame's channel id is queued in a tag FIFO and re-attached
//   (with start/end-of-frame markers) to the FFT output stream.
//   Ports:
//     clock  master clock
//     reset  asynchronous, active-high; clears all state and outputs
//     bus    fft_frame_scheduler_if.master (channel side, FFT in/out, results,
//            busy, err[0]=orphan output, err[1]=broken output frame)
//   Parameters: N (points, pow2 >= 4), WIDTH, NCH (2..8),
//               MAX_OUT (tag FIFO depth, pow2 >= 2), GAP (0..15 idle cycles)
module fft_frame_scheduler #(
   parameter int N       = 64,
   parameter int WIDTH   = 16,
   parameter int NCH     = 2,
   parameter int MAX_OUT = 4,
   parameter int GAP     = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   fft_frame_scheduler_if.master bus
);
   localparam int CHW  = $clog2(NCH);
   localparam int CNTW = $clog2(N);
   localparam int PW   = $clog2(MAX_OUT);
   localparam int TCW  = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

   state_t          state, state_nxt;
   logic [CNTW-1:0] cnt, cnt_nxt;
   logic [3:0]      gcnt, gcnt_nxt;
   logic [CHW-1:0]  sel, sel_nxt;
   logic [CHW-1:0]  last_win;
   logic [CHW-1:0]  win_id;
   logic            win_found;
   logic            grant_ok;
   logic            push;
   logic            pop;
   int              idx;

   logic [CHW-1:0]  tag_mem [MAX_OUT];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [TCW-1:0]  tag_cnt;
   logic [CNTW-1:0] ocnt;

   // Round-robin search: first requester above the last winner, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = int'(last_win) + k;
         if (idx >= NCH) idx = idx - NCH;
         if (!win_found && bus.ch_req[idx]) begin
            win_found = 1'b1;
            win_id    = CHW'(idx);
         end
      end
   end

   // Tag count is taken before this cycle's pop, so a full FIFO never grants
   // in the same cycle that a result frame completes.
   assign grant_ok = win_found && (tag_cnt < TCW'(MAX_OUT));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      gcnt_nxt  = gcnt;
      sel_nxt   = sel;
      push      = 1'b0;
      case (state)
         S_IDLE: begin
            if (grant_ok) begin
               state_nxt = S_STREAM;
               cnt_nxt   = '0;
               sel_nxt   = win_id;
               push      = 1'b1;
            end
         end
         S_STREAM: begin
            if (cnt == CNTW'(N - 1)) begin
               if (GAP > 0) begin
                  state_nxt = S_GAP;
                  gcnt_nxt  = '0;
               end else if (grant_ok) begin
                  // Back-to-back frame: stay in STREAM so di_en never drops.
                  cnt_nxt = '0;
                  sel_nxt = win_id;
                  push    = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_GAP: begin
            if (gcnt == 4'(GAP - 1)) state_nxt = S_IDLE;
            else                     gcnt_nxt  = gcnt + 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Stage p0: FSM state and registered channel read strobe
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         gcnt      <= '0;
         sel       <= '0;
         last_win  <= CHW'(NCH - 1);
         bus.ch_rd <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         gcnt      <= gcnt_nxt;
         sel       <= sel_nxt;
         if (push) last_win <= win_id;
         bus.ch_rd <= (state_nxt == S_STREAM) ? (NCH'(1) << sel_nxt) : '0;
      end
   end

   // Stage p1: FFT input, one cycle behind ch_rd (FWFT data valid with ch_rd)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.fft_di_en <= 1'b0;
         bus.fft_di_re <= '0;
         bus.fft_di_im <= '0;
      end else begin
         bus.fft_di_en <= |bus.ch_rd;
         bus.fft_di_re <= $signed(bus.ch_di_re[sel*WIDTH +: WIDTH]);
         bus.fft_di_im <= $signed(bus.ch_di_im[sel*WIDTH +: WIDTH]);
      end
   end

   // Tag FIFO storage
   always_ff @(posedge clock) begin
      if (push) tag_mem[wr_ptr] <= win_id;
   end

   assign pop = bus.fft_do_en && (tag_cnt != '0) && (ocnt == CNTW'(N - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: tag_cnt <= tag_cnt;
         endcase
      end
   end

   // Stage p2: tagged result stream and sticky error flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.out_en  <= 1'b0;
         bus.out_re  <= '0;
         bus.out_im  <= '0;
         bus.out_ch  <= '0;
         bus.out_sof <= 1'b0;
         bus.out_eof <= 1'b0;
         bus.err     <= 2'b00;
         ocnt        <= '0;
      end else begin
         bus.out_re  <= bus.fft_do_re;
         bus.out_im  <= bus.fft_do_im;
         bus.out_ch  <= tag_mem[rd_ptr];
         bus.out_en  <= 1'b0;
         bus.out_sof <= 1'b0;
         bus.out_eof <= 1'b0;
         if (bus.fft_do_en) begin
            if (tag_cnt == '0) begin
               // Nothing to attach this sample to: flag it and suppress it.
               bus.err[0] <= 1'b1;
            end else begin
               bus.out_en  <= 1'b1;
               bus.out_sof <= (ocnt == '0);
               bus.out_eof <= (ocnt == CNTW'(N - 1));
               ocnt        <= (ocnt == CNTW'(N - 1)) ? '0 : ocnt + 1'b1;
            end
         end else if (ocnt != '0) begin
            // Hole inside an output frame; the count holds so the frame resumes.
            bus.err[1] <= 1'b1;
         end
      end
   end

   assign bus.busy = (state != S_IDLE) || (tag_cnt != '0);

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler
//   Drives two schedulers (GAP=0 and GAP=3) with randomized channel data,
//   scripted request patterns and a stand-in FFT, and compares every cycle
//   against a frame/queue-level reference model of the scheduling rules.
module tb_fft_frame_scheduler;
   localparam int N       = 64;
   localparam int WIDTH   = 16;
   localparam int NCH     = 2;
   localparam int CHW     = $clog2(NCH);
   localparam int MAX_OUT = 4;
   localparam int ND      = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [NCH*WIDTH-1:0]    di_re, di_im;
   logic [NCH-1:0]          req    [ND];
   logic                    do_en  [ND];
   logic signed [WIDTH-1:0] do_re  [ND];
   logic signed [WIDTH-1:0] do_im  [ND];

   logic [NCH-1:0]          o_rd    [ND];
   logic                    o_di_en [ND];
   logic signed [WIDTH-1:0] o_di_re [ND];
   logic signed [WIDTH-1:0] o_di_im [ND];
   logic                    o_en    [ND];
   logic signed [WIDTH-1:0] o_re    [ND];
   logic signed [WIDTH-1:0] o_im    [ND];
   logic [CHW-1:0]          o_ch    [ND];
   logic                    o_sof   [ND];
   logic                    o_eof   [ND];
   logic                    o_busy  [ND];
   logic [1:0]              o_err   [ND];

   for (genvar g = 0; g < ND; g++) begin : gen_dut
      fft_frame_scheduler_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();
      fft_frame_scheduler #(.N(N), .WIDTH(WIDTH), .NCH(NCH), .MAX_OUT(MAX_OUT), .GAP(g * 3)) dut (
         .clock (clock),
         .reset (reset),
         .bus   (bus)
      );
      assign bus.ch_req    = req[g];
      assign bus.ch_di_re  = di_re;
      assign bus.ch_di_im  = di_im;
      assign bus.fft_do_en = do_en[g];
      assign bus.fft_do_re = do_re[g];
      assign bus.fft_do_im = do_im[g];
      assign o_rd[g]    = bus.ch_rd;
      assign o_di_en[g] = bus.fft_di_en;
      assign o_di_re[g] = bus.fft_di_re;
      assign o_di_im[g] = bus.fft_di_im;
      assign o_en[g]    = bus.out_en;
      assign o_re[g]    = bus.out_re;
      assign o_im[g]    = bus.out_im;
      assign o_ch[g]    = bus.out_ch;
      assign o_sof[g]   = bus.out_sof;
      assign o_eof[g]   = bus.out_eof;
      assign o_busy[g]  = bus.busy;
      assign o_err[g]   = bus.err;
   end

   // Reference model: which channel is being read and how many reads remain,
   // remaining gap cycles, last winner, and a ring of outstanding frame tags.
   int rd_ch [ND], left [ND], gapl [ND], last [ND], ocnt [ND], th [ND], tn [ND];
   int tq [ND][8];
   logic                    e_di_en [ND];
   logic signed [WIDTH-1:0] e_di_re [ND], e_di_im [ND], e_re [ND], e_im [ND];
   logic                    e_en [ND], e_sof [ND], e_eof [ND];
   int                      e_ch [ND];
   logic [1:0]              e_err [ND];

   // Stand-in FFT state and stimulus controls
   int             f_left [ND], f_idx [ND];
   bit             drop_req [ND];
   bit             f_on, orphan, rand_req;
   logic [NCH-1:0] cur_req;
   int             total = 0, bad = 0;

   task automatic chk_eq(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset(input int d);
      rd_ch[d] = -1; left[d] = 0; gapl[d] = 0; last[d] = NCH - 1;
      ocnt[d] = 0; th[d] = 0; tn[d] = 0;
      e_di_en[d] = 0; e_di_re[d] = '0; e_di_im[d] = '0;
      e_en[d] = 0; e_re[d] = '0; e_im[d] = '0; e_ch[d] = 0;
      e_sof[d] = 0; e_eof[d] = 0; e_err[d] = 2'b00;
   endtask

   task automatic try_grant(input int d, input int cb);
      int w;
      w = -1;
      if (cb < MAX_OUT)
         for (int k = 1; k <= NCH; k++)
            if (w < 0 && req[d][(last[d] + k) % NCH]) w = (last[d] + k) % NCH;
      if (w >= 0) begin
         rd_ch[d] = w; left[d] = N - 1; last[d] = w;
         tq[d][(th[d] + tn[d]) % 8] = w;
         tn[d]++;
      end
   endtask

   task automatic model_update(input int d);
      int cb;
      if (reset) begin
         model_reset(d);
         return;
      end
      e_di_en[d] = (rd_ch[d] >= 0);
      if (rd_ch[d] >= 0) begin
         e_di_re[d] = di_re[rd_ch[d]*WIDTH +: WIDTH];
         e_di_im[d] = di_im[rd_ch[d]*WIDTH +: WIDTH];
      end
      cb = tn[d];
      e_re[d] = do_re[d]; e_im[d] = do_im[d];
      e_en[d] = 0; e_sof[d] = 0; e_eof[d] = 0;
      if (do_en[d]) begin
         if (cb == 0) e_err[d][0] = 1'b1;
         else begin
            e_en[d] = 1; e_ch[d] = tq[d][th[d]];
            e_sof[d] = (ocnt[d] == 0); e_eof[d] = (ocnt[d] == N - 1);
            if (ocnt[d] == N - 1) begin
               ocnt[d] = 0; th[d] = (th[d] + 1) % 8; tn[d]--;
            end else ocnt[d]++;
         end
      end else if (ocnt[d] != 0) e_err[d][1] = 1'b1;
      if (rd_ch[d] >= 0 && left[d] > 0) left[d]--;
      else if (rd_ch[d] >= 0) begin
         rd_ch[d] = -1;
         if (d * 3 > 0) gapl[d] = d * 3;
         else           try_grant(d, cb);
      end else if (gapl[d] > 0) gapl[d]--;
      else try_grant(d, cb);
   endtask

   task automatic check_all(input int d);
      logic [NCH-1:0] er;
      er = (rd_ch[d] >= 0) ? NCH'(1) << rd_ch[d] : '0;
      chk_eq($sformatf("d%0d ch_rd", d), o_rd[d], er);
      chk_eq($sformatf("d%0d fft_di_en", d), o_di_en[d], e_di_en[d]);
      if (e_di_en[d]) begin
         chk_eq($sformatf("d%0d fft_di_re", d), o_di_re[d], e_di_re[d]);
         chk_eq($sformatf("d%0d fft_di_im", d), o_di_im[d], e_di_im[d]);
      end
      chk_eq($sformatf("d%0d out_en", d), o_en[d], e_en[d]);
      chk_eq($sformatf("d%0d out_re", d), o_re[d], e_re[d]);
      chk_eq($sformatf("d%0d out_im", d), o_im[d], e_im[d]);
      if (e_en[d]) chk_eq($sformatf("d%0d out_ch", d), o_ch[d], e_ch[d]);
      chk_eq($sformatf("d%0d out_sof", d), o_sof[d], e_sof[d]);
      chk_eq($sformatf("d%0d out_eof", d), o_eof[d], e_eof[d]);
      chk_eq($sformatf("d%0d busy", d), o_busy[d],
             (rd_ch[d] >= 0) || (gapl[d] > 0) || (tn[d] > 0));
      chk_eq($sformatf("d%0d err", d), o_err[d], e_err[d]);
   endtask

   task automatic drive();
      for (int c = 0; c < NCH; c++) begin
         di_re[c*WIDTH +: WIDTH] = WIDTH'($urandom);
         di_im[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      if (rand_req && $urandom_range(0, 15) == 0) cur_req = NCH'($urandom);
      for (int d = 0; d < ND; d++) begin
         for (int c = 0; c < NCH; c++)
            req[d][c] = (d == 0) ? cur_req[c] : cur_req[NCH-1-c];
         do_en[d] = 1'b0;
         do_re[d] = WIDTH'($urandom);
         do_im[d] = WIDTH'($urandom);
         if (reset) begin
            f_left[d] = 0; drop_req[d] = 0;
         end else if (orphan) begin
            do_en[d] = 1'b1;
         end else if (f_left[d] > 0) begin
            if (drop_req[d] && f_idx[d] == 10) drop_req[d] = 0;
            else begin
               do_en[d] = 1'b1; f_left[d]--; f_idx[d]++;
            end
         end else if (f_on && tn[d] > 0 && $urandom_range(0, 1) == 1) begin
            do_en[d] = 1'b1; f_left[d] = N - 1; f_idx[d] = 1;
         end
      end
      orphan = 0;
   endtask

   task automatic step();
      @(posedge clock);
      for (int d = 0; d < ND; d++) model_update(d);
      @(negedge clock);
      for (int d = 0; d < ND; d++) check_all(d);
      drive();
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      bit found;
      f_on = 0; orphan = 0; rand_req = 0; cur_req = '0;
      for (int d = 0; d < ND; d++) begin
         f_left[d] = 0; f_idx[d] = 0; drop_req[d] = 0;
         model_reset(d);
      end
      drive();
      run(3);
      reset = 1'b0;

      cur_req = 2'b01; f_on = 1; run(200);     // single requester, back-to-back
      cur_req = 2'b11; run(300);               // alternating grants
      f_on = 0; run(400);                      // FFT stalled: tag FIFO fills
      f_on = 1; rand_req = 1; run(600);        // drain plus random requests
      rand_req = 0; cur_req = 2'b00; run(400); // idle and fully drained
      orphan = 1; run(3);                      // output sample with no tag
      cur_req = 2'b01; drop_req[0] = 1; drop_req[1] = 1; run(200);

      cur_req = 2'b11;
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step();
         if (rd_ch[0] >= 0 && left[0] == N - 1 - 20) found = 1;
      end
      chk_eq("reset_wait", found, 1);
      reset = 1'b1;
      #1;
      for (int d = 0; d < ND; d++) begin
         chk_eq($sformatf("d%0d rst ch_rd", d), o_rd[d], 0);
         chk_eq($sformatf("d%0d rst fft_di_en", d), o_di_en[d], 0);
         chk_eq($sformatf("d%0d rst busy", d), o_busy[d], 0);
      end
      run(2);
      reset = 1'b0;
      run(150);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
